// File: rtl/mips_cpu_ctrl_pkg.sv
// Shared types and constants for the mips_cpu_harvard run controller.
package mips_cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET_CPU,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } run_state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

   // A new run may only begin from a resting state; start is ignored while busy.
   function automatic logic accepts_start(input run_state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/mips_cpu_cycle_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module mips_cpu_cycle_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         at_limit
);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   assign at_limit = (count == limit);

endmodule

// File: rtl/mips_cpu_run_controller.sv
// Sequences one mips_cpu_harvard run: CPU reset, gated free-run/single-step
// execution, halt detection with v0 capture, cycle counting and timeout.
module mips_cpu_run_controller
   import mips_cpu_ctrl_pkg::*;
#(
   parameter int          RESET_CYCLES   = 2,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 32,
   parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             step_mode,
   input  logic             step,
   input  logic             cpu_active,
   input  logic [31:0]      cpu_instr_address,
   input  logic [31:0]      cpu_register_v0,
   output logic             cpu_reset,
   output logic             cpu_clk_enable,
   output logic             busy,
   output logic             done,
   output logic             timed_out,
   output logic             vector_error,
   output logic [31:0]      result,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   run_state_t       state;
   logic             start_ok;
   logic             run_en;
   logic             rst_cnt_en;
   logic             cyc_cnt_en;
   logic             rst_last;
   logic             run_last;
   logic             first_cycle;
   logic             halt;
   logic             timeout_hit;
   logic [RST_W-1:0] rst_cnt_unused;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      cpu_reset      = 1'b1;
      cpu_clk_enable = 1'b0;
      unique case (state)
         ST_RESET_CPU: cpu_clk_enable = 1'b1;
         ST_RUN: begin
            cpu_reset      = 1'b0;
            cpu_clk_enable = step_mode ? step : 1'b1;
         end
         ST_DONE, ST_TIMEOUT: cpu_reset = 1'b0;
         default: ;
      endcase
   end

   assign start_ok    = start && !abort && accepts_start(state);
   assign run_en      = (state == ST_RUN) && cpu_clk_enable;
   assign rst_cnt_en  = (state == ST_RESET_CPU) && !abort;
   assign cyc_cnt_en  = run_en && !abort;
   assign first_cycle = (cycle_count == '0);
   // The CPU reports inactive only once it has executed; ignore the first cycle.
   assign halt        = run_en && !cpu_active && !first_cycle;
   assign timeout_hit = run_en && run_last;

   mips_cpu_cycle_counter #(.W(RST_W)) u_rst_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (start_ok),
      .en       (rst_cnt_en),
      .limit    (RST_LAST),
      .count    (rst_cnt_unused),
      .at_limit (rst_last)
   );

   mips_cpu_cycle_counter #(.W(CNT_W)) u_cyc_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (start_ok),
      .en       (cyc_cnt_en),
      .limit    (RUN_LAST),
      .count    (cycle_count),
      .at_limit (run_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         timed_out    <= 1'b0;
         vector_error <= 1'b0;
         result       <= '0;
      end else if (abort) begin
         // result and vector_error stay visible until the next start
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
               if (start) begin
                  state        <= ST_RESET_CPU;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  timed_out    <= 1'b0;
                  vector_error <= 1'b0;
                  result       <= '0;
               end
            end
            ST_RESET_CPU: begin
               if (rst_last) state <= ST_RUN;
            end
            ST_RUN: begin
               if (run_en && first_cycle && (cpu_instr_address != RESET_VECTOR)) begin
                  vector_error <= 1'b1;
               end
               if (halt) begin
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= cpu_register_v0;
               end else if (timeout_hit) begin
                  state     <= ST_TIMEOUT;
                  busy      <= 1'b0;
                  timed_out <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_run_controller.sv
// Scoreboard bench for mips_cpu_run_controller driving a behavioural CPU model.
module tb_mips_cpu_run_controller;
   import mips_cpu_ctrl_pkg::*;

   localparam int RESET_CYCLES   = 2;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int CNT_W          = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             step_mode = 1'b0;
   logic             step = 1'b0;
   logic             cpu_active = 1'b1;
   logic [31:0]      cpu_instr_address = '0;
   logic [31:0]      cpu_register_v0 = '0;
   logic             cpu_reset;
   logic             cpu_clk_enable;
   logic             busy;
   logic             done;
   logic             timed_out;
   logic             vector_error;
   logic [31:0]      result;
   logic [CNT_W-1:0] cycle_count;

   always #5 clk = ~clk;

   mips_cpu_run_controller #(
      .RESET_CYCLES   (RESET_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VECTOR   (DEFAULT_RESET_VECTOR)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .step_mode         (step_mode),
      .step              (step),
      .cpu_active        (cpu_active),
      .cpu_instr_address (cpu_instr_address),
      .cpu_register_v0   (cpu_register_v0),
      .cpu_reset         (cpu_reset),
      .cpu_clk_enable    (cpu_clk_enable),
      .busy              (busy),
      .done              (done),
      .timed_out         (timed_out),
      .vector_error      (vector_error),
      .result            (result),
      .cycle_count       (cycle_count)
   );

   // CPU model: halt_after=N drops active during the Nth enabled run cycle; 0 = never.
   int          halt_after = 0;
   logic [31:0] first_pc = DEFAULT_RESET_VECTOR;
   logic [31:0] v0_val = '0;
   int          m_n = 0;

   always @(posedge clk) begin
      if (cpu_reset) begin
         cpu_instr_address <= first_pc;
         cpu_active        <= 1'b1;
         cpu_register_v0   <= '0;
         m_n               <= 0;
      end else if (cpu_clk_enable && cpu_active) begin
         m_n <= m_n + 1;
         if (m_n + 1 == halt_after - 1) begin
            cpu_active        <= 1'b0;
            cpu_instr_address <= '0;
            cpu_register_v0   <= v0_val;
         end else begin
            cpu_instr_address <= cpu_instr_address + 32'd4;
         end
      end
   end

   int rst_en_total = 0;
   int run_en_total = 0;

   always @(negedge clk) begin
      if (cpu_reset && cpu_clk_enable)  rst_en_total <= rst_en_total + 1;
      if (!cpu_reset && cpu_clk_enable) run_en_total <= run_en_total + 1;
   end

   typedef struct {
      logic        done;
      logic        timed_out;
      logic [31:0] result;
      logic [31:0] cycles;
      logic        vector_error;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Monitor: each run ending (done or timed_out rising) retires one expectation.
   logic term_q = 1'b0;
   always @(negedge clk) begin
      if ((done || timed_out) && !term_q) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_end", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_done",         {31'd0, done},         {31'd0, mon_e.done});
            check("sb_timed_out",    {31'd0, timed_out},    {31'd0, mon_e.timed_out});
            check("sb_result",       result,                mon_e.result);
            check("sb_cycle_count",  cycle_count,           mon_e.cycles);
            check("sb_vector_error", {31'd0, vector_error}, {31'd0, mon_e.vector_error});
            check("sb_busy",         {31'd0, busy},         32'd0);
            check("sb_clk_enable",   {31'd0, cpu_clk_enable}, 32'd0);
         end
      end
      term_q <= done || timed_out;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_to_end(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ends"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int rb;
   int eb;

   initial begin
      // Reset state
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rst_cpu_reset",    {31'd0, cpu_reset},      32'd1);
      check("rst_clk_enable",   {31'd0, cpu_clk_enable}, 32'd0);
      check("rst_busy",         {31'd0, busy},           32'd0);
      check("rst_done",         {31'd0, done},           32'd0);
      check("rst_timed_out",    {31'd0, timed_out},      32'd0);
      check("rst_vector_error", {31'd0, vector_error},   32'd0);
      check("rst_result",       result,                  32'd0);
      check("rst_cycle_count",  cycle_count,             32'd0);

      // Normal run: halts on the 7th enabled cycle with v0=4
      halt_after = 7; v0_val = 32'd4; first_pc = DEFAULT_RESET_VECTOR;
      rb = rst_en_total; eb = run_en_total;
      exp_q.push_back('{done: 1'b1, timed_out: 1'b0, result: 32'd4, cycles: 32'd7, vector_error: 1'b0});
      pulse_start();
      run_to_end("normal", 200);
      check("normal_rst_cycles", rb == 0 ? rst_en_total : rst_en_total - rb, 32'd2);
      check("normal_en_cycles",  run_en_total - eb, 32'd7);
      check("normal_cpu_reset",  {31'd0, cpu_reset}, 32'd0);

      // Timeout from DONE; a start mid-run must be ignored
      halt_after = 0;
      rb = rst_en_total; eb = run_en_total;
      exp_q.push_back('{done: 1'b0, timed_out: 1'b1, result: 32'd0, cycles: 32'd20, vector_error: 1'b0});
      pulse_start();
      repeat (6) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      run_to_end("timeout", 200);
      check("timeout_rst_cycles", rst_en_total - rb, 32'd2);
      check("timeout_en_cycles",  run_en_total - eb, 32'd20);

      // Halt and timeout in the same cycle: halt wins
      halt_after = TIMEOUT_CYCLES; v0_val = 32'h1234_5678;
      eb = run_en_total;
      exp_q.push_back('{done: 1'b1, timed_out: 1'b0, result: 32'h1234_5678, cycles: 32'd20, vector_error: 1'b0});
      pulse_start();
      run_to_end("halt_at_limit", 200);
      check("halt_at_limit_en_cycles", run_en_total - eb, 32'd20);

      // Single-step: three step pulses five cycles apart
      halt_after = 0; step_mode = 1'b1;
      rb = rst_en_total; eb = run_en_total;
      pulse_start();
      repeat (4) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         repeat (5) @(posedge clk);
         #1 step = 1'b1;
         @(posedge clk); #1 step = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("step_rst_cycles", rst_en_total - rb, 32'd2);
      check("step_en_cycles",  run_en_total - eb, 32'd3);
      check("step_cycle_count", cycle_count, 32'd3);
      check("step_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy",        {31'd0, busy},      32'd0);
      check("abort_cpu_reset",   {31'd0, cpu_reset}, 32'd1);
      check("abort_cycle_count", cycle_count,        32'd3);
      step_mode = 1'b0;

      // Bad reset vector, then abort and start together
      first_pc = 32'hBFC0_0004; halt_after = 0;
      pulse_start();
      repeat (6) @(negedge clk);
      check("vec_error_set", {31'd0, vector_error}, 32'd1);
      check("vec_run_continues", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 abort = 1'b1; start = 1'b1;
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      @(negedge clk);
      check("abort_start_busy",       {31'd0, busy},           32'd0);
      check("abort_start_cpu_reset",  {31'd0, cpu_reset},      32'd1);
      check("abort_start_clk_enable", {31'd0, cpu_clk_enable}, 32'd0);
      check("abort_start_vec_hold",   {31'd0, vector_error},   32'd1);

      // Restart with a good vector: vector_error must clear
      first_pc = DEFAULT_RESET_VECTOR; halt_after = 3; v0_val = 32'd9;
      exp_q.push_back('{done: 1'b1, timed_out: 1'b0, result: 32'd9, cycles: 32'd3, vector_error: 1'b0});
      pulse_start();
      run_to_end("restart", 200);

      // Controller reset in the middle of a run
      halt_after = 0;
      pulse_start();
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_busy",        {31'd0, busy},           32'd0);
      check("midrst_cpu_reset",   {31'd0, cpu_reset},      32'd1);
      check("midrst_clk_enable",  {31'd0, cpu_clk_enable}, 32'd0);
      check("midrst_cycle_count", cycle_count,             32'd0);
      check("midrst_result",      result,                  32'd0);

      repeat (2) @(negedge clk);
      check("sb_drain", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
